// File: rtl/ritc_align_sequencer_pkg.sv
// Shared definitions for the RITC datapath alignment sequencer: register map, field positions,
// sweep geometry and the controller state encoding.
package ritc_align_sequencer_pkg;

  localparam logic [3:0] AddrDpTraining = 4'd2;
  localparam logic [3:0] AddrDpIdelay   = 4'd4;

  localparam int unsigned LoadBit = 31;
  localparam int unsigned SlipBit = 30;
  localparam int unsigned SelLsb  = 16;
  localparam int unsigned SelW    = 7;
  localparam int unsigned TapW    = 5;

  localparam int unsigned NumCh  = 6;
  localparam int unsigned NumBit = 12;

  localparam logic [TapW-1:0] LastTap = '1;
  localparam logic [2:0]      LastCh  = 3'(NumCh - 1);
  localparam logic [3:0]      LastBit = 4'(NumBit - 1);

  typedef enum logic [3:0] {
    StIdle,
    StSetDly,
    StSetTrn,
    StSettle,
    StSample,
    StEval,
    StDecide,
    StApply,
    StSlip,
    StSettleS,
    StNextBit,
    StDone
  } state_e;

  // DPIDELAY write: load strobe, target bit select and tap value.
  function automatic logic [31:0] idelay_word(input logic [SelW-1:0] sel,
                                               input logic [TapW-1:0] tap);
    logic [31:0] w;
    w                  = '0;
    w[LoadBit]         = 1'b1;
    w[SelLsb +: SelW]  = sel;
    w[TapW-1:0]        = tap;
    return w;
  endfunction

  // DPTRAINING write: training enabled (bit 31 low), optional bitslip, bit select.
  function automatic logic [31:0] training_word(input logic [SelW-1:0] sel, input logic slip);
    logic [31:0] w;
    w                  = '0;
    w[SlipBit]         = slip;
    w[SelLsb +: SelW]  = sel;
    return w;
  endfunction

endpackage

// File: rtl/ritc_eye_tracker.sv
// Tracks the current and widest run of matching taps across one IDELAY sweep and reports the
// centre of the widest run.
module ritc_eye_tracker
  import ritc_align_sequencer_pkg::*;
#(
  parameter int unsigned MIN_EYE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            eval,
  input  logic            match,
  input  logic [TapW-1:0] tap,
  output logic            eye_ok,
  output logic [TapW-1:0] centre
);

  logic [TapW:0]   run_len_q, run_len_d;
  logic [TapW-1:0] run_start_q, run_start_d;
  logic [TapW:0]   best_len_q;
  logic [TapW-1:0] best_start_q;

  always_comb begin
    run_len_d   = match ? run_len_q + 1'b1 : '0;
    run_start_d = (match && (run_len_q == '0)) ? tap : run_start_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else if (clear) begin
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else if (eval) begin
      run_len_q   <= run_len_d;
      run_start_q <= run_start_d;
      // Strictly greater: on a tie the earlier run is kept.
      if (run_len_d > best_len_q) begin
        best_len_q   <= run_len_d;
        best_start_q <= run_start_d;
      end
    end
  end

  assign eye_ok = (best_len_q >= (TapW+1)'(MIN_EYE));
  // A run never extends past tap 31, so start + len/2 stays within 5 bits.
  assign centre = best_start_q + best_len_q[TapW:1];

endmodule

// File: rtl/ritc_align_sequencer.sv
// Autonomous IDELAY/bitslip training master for the dual-RITC datapath register bus; passes host
// accesses through while idle.
module ritc_align_sequencer
  import ritc_align_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MIN_EYE       = 3,
  parameter int unsigned MAX_SLIP      = 4
) (
  input  logic        user_clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  pattern_i,
  input  logic        host_sel_i,
  input  logic        host_wr_i,
  input  logic [3:0]  host_addr_i,
  input  logic [31:0] host_dat_i,
  output logic [31:0] host_dat_o,
  output logic        bus_sel_o,
  output logic        bus_wr_o,
  output logic [3:0]  bus_addr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [6:0]  fail_count_o,
  output logic [6:0]  cur_bit_o
);

  localparam int unsigned CntW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SlipW = $clog2(MAX_SLIP + 1);
  localparam logic [CntW-1:0]  SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [SlipW-1:0] SlipMax    = SlipW'(MAX_SLIP);

  state_e           state_q, state_d;
  logic [TapW-1:0]  tap_q, tap_d;
  logic [SlipW-1:0] slip_q, slip_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       ch_q, ch_d;
  logic [3:0]       bit_q, bit_d;
  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic [6:0]       fail_cnt_q, fail_cnt_d;

  logic             trk_clear, trk_eval, eye_ok;
  logic [TapW-1:0]  centre;
  logic [SelW-1:0]  sel;

  assign sel = {ch_q, bit_q};

  ritc_eye_tracker #(
    .MIN_EYE (MIN_EYE)
  ) u_eye_tracker (
    .clk    (user_clk_i),
    .rst    (rst_i),
    .clear  (trk_clear),
    .eval   (trk_eval),
    .match  (match_q),
    .tap    (tap_q),
    .eye_ok (eye_ok),
    .centre (centre)
  );

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    slip_d     = slip_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    bit_d      = bit_q;
    match_d    = match_q;
    fail_d     = fail_q;
    fail_cnt_d = fail_cnt_q;
    trk_clear  = 1'b0;
    trk_eval   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          fail_d     = 1'b0;
          fail_cnt_d = '0;
          tap_d      = '0;
          slip_d     = '0;
          ch_d       = '0;
          bit_d      = '0;
          trk_clear  = 1'b1;
          state_d    = StSetDly;
        end
      end
      StSetDly: state_d = StSetTrn;
      StSetTrn: begin
        cnt_d   = SettleLoad;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSample: begin
        match_d = (bus_dat_i[7:0] == pattern_i);
        state_d = StEval;
      end
      StEval: begin
        trk_eval = 1'b1;
        if (tap_q == LastTap) begin
          state_d = StDecide;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = StSetDly;
        end
      end
      StDecide: begin
        if (eye_ok) begin
          state_d = StApply;
        end else if (slip_q < SlipMax) begin
          state_d = StSlip;
        end else begin
          fail_cnt_d = fail_cnt_q + 7'd1;
          fail_d     = 1'b1;
          state_d    = StNextBit;
        end
      end
      StApply: state_d = StNextBit;
      StSlip: begin
        slip_d    = slip_q + 1'b1;
        tap_d     = '0;
        trk_clear = 1'b1;
        cnt_d     = SettleLoad;
        state_d   = StSettleS;
      end
      StSettleS: begin
        if (cnt_q == '0) begin
          state_d = StSetDly;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StNextBit: begin
        if ((bit_q == LastBit) && (ch_q == LastCh)) begin
          state_d = StDone;
        end else begin
          if (bit_q == LastBit) begin
            bit_d = '0;
            ch_d  = ch_q + 3'd1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
          slip_d    = '0;
          tap_d     = '0;
          trk_clear = 1'b1;
          state_d   = StSetDly;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus mux: host passthrough only in IDLE; otherwise single-cycle master accesses per state.
  always_comb begin
    bus_sel_o  = 1'b0;
    bus_wr_o   = 1'b0;
    bus_addr_o = '0;
    bus_dat_o  = '0;

    unique case (state_q)
      StIdle: begin
        if (!rst_i) begin
          bus_sel_o  = host_sel_i;
          bus_wr_o   = host_wr_i;
          bus_addr_o = host_addr_i;
          bus_dat_o  = host_dat_i;
        end
      end
      StSetDly: begin
        bus_sel_o  = 1'b1;
        bus_wr_o   = 1'b1;
        bus_addr_o = AddrDpIdelay;
        bus_dat_o  = idelay_word(sel, tap_q);
      end
      StSetTrn: begin
        bus_sel_o  = 1'b1;
        bus_wr_o   = 1'b1;
        bus_addr_o = AddrDpTraining;
        bus_dat_o  = training_word(sel, 1'b0);
      end
      StSample: begin
        bus_sel_o  = 1'b1;
        bus_addr_o = AddrDpTraining;
      end
      StApply: begin
        bus_sel_o  = 1'b1;
        bus_wr_o   = 1'b1;
        bus_addr_o = AddrDpIdelay;
        bus_dat_o  = idelay_word(sel, centre);
      end
      StSlip: begin
        bus_sel_o  = 1'b1;
        bus_wr_o   = 1'b1;
        bus_addr_o = AddrDpTraining;
        bus_dat_o  = training_word(sel, 1'b1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tap_q      <= '0;
      slip_q     <= '0;
      cnt_q      <= '0;
      ch_q       <= '0;
      bit_q      <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      slip_q     <= slip_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign host_dat_o   = bus_dat_i;
  assign busy_o       = (state_q != StIdle) && (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign fail_o       = fail_q;
  assign fail_count_o = fail_cnt_q;
  assign cur_bit_o    = sel;

endmodule

// File: doc/ritc_align_sequencer.md
Name: ritc_align_sequencer

Overview:
Autonomous training/alignment controller for the dual-RITC datapath. It acts as a master on the datapath register bus (addr 2 = DPTRAINING, addr 4 = DPIDELAY) and handles each of the 72 data bits (6 ch x 12 bit) in turn:
- sweeps IDELAY taps 0-31 and samples the latched training byte;
- finds the widest contiguous run of matching taps and loads the tap at its centre;
- issues BITSLIPs when no adequate eye is found.
While idle it passes the host's register accesses straight through to the datapath.

Parameters:
SETTLE_CYCLES, 64, user_clk_i cycles waited after each delay load/bitslip before sampling
MIN_EYE, 3, minimum run of matching taps accepted as a valid eye
MAX_SLIP, 4, bitslips tried per bit before the bit is declared failed

Ports:
user_clk_i  in  1  register-bus clock; the only clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse; starts alignment of all 72 bits (ignored while busy)
pattern_i  in  8  expected training byte
host_sel_i  in  1  host bus select
host_wr_i  in  1  host write strobe
host_addr_i  in  4  host address
host_dat_i  in  32  host write data
host_dat_o  out  32  host read data (= bus_dat_i)
bus_sel_o  out  1  datapath select
bus_wr_o  out  1  datapath write
bus_addr_o  out  4  datapath address
bus_dat_o  out  32  datapath write data
bus_dat_i  in  32  datapath read data (combinational from addr)
busy_o  out  1  sequence running
done_o  out  1  one-cycle pulse at sequence end
fail_o  out  1  sticky: at least one bit failed; cleared on start
fail_count_o  out  7  number of failed bits
cur_bit_o  out  7  {ch[2:0],bit[3:0]} currently processed

Behaviour:
- Reset: all outputs 0; state IDLE; bus outputs 0.
- Arbitration:
  - In IDLE, bus_* = host_* combinationally, and host_dat_o = bus_dat_i always.
  - When busy, host_sel_i is ignored (dropped, no stall) and bus_* is driven from registers.
- Bit order: ch 0..5 outer, bit 0..11 inner. Select field = {ch,bit}; bits 12-15 are never visited.
- States:
  - IDLE: on start_i -> busy_o=1, fail_o=0, fail_count_o=0, tap=0, slip=0, best_len=0, run_len=0 -> SET_DLY.
  - SET_DLY: 1 cycle, write addr 4, data {1'b1, 8'b0, sel[6:0], 11'b0, tap[4:0]}.
  - SET_TRN: 1 cycle, write addr 2, data {1'b0, 1'b0, 7'b0, sel, 16'b0} (training enabled, select this bit).
  - SETTLE: counter SETTLE_CYCLES-1 down to 0.
  - SAMPLE: sel=1, wr=0, addr=2; register match = (bus_dat_i[7:0]==pattern_i) that same cycle.
  - EVAL: 1 cycle.
    - match: run_len++, and record run_start=tap if run_len was 0.
    - no match: run_len=0.
    - If the updated run_len > best_len, update best_len/best_start. Strictly greater, so the first longest run wins.
    - tap<31: tap++ -> SET_DLY. tap==31: -> DECIDE.
  - DECIDE:
    - best_len>=MIN_EYE: centre = best_start + (best_len>>1), 5-bit, no wrap possible -> APPLY.
    - Otherwise, slip<MAX_SLIP -> SLIP.
    - Otherwise, fail_count++, fail_o=1 -> NEXT_BIT.
  - APPLY: write addr 4 with tap=centre and load=1 -> NEXT_BIT.
  - SLIP: write addr 2 with bit30=1 and sel. Then slip++, tap=0, best/run cleared -> SETTLE_S (SETTLE_CYCLES) -> SET_DLY.
  - NEXT_BIT: bit 11 -> next ch, bit 0. Last ch 5 bit 11 -> DONE. Otherwise slip=0, tap=0, best/run cleared -> SET_DLY.
  - DONE: done_o=1 for 1 cycle, busy_o=0 -> IDLE.
- Bus timing: each write is a single-cycle sel&wr. The bus is idle (sel=0) in all other busy states.
- A run reaching tap 31 is still evaluated, because the best update is done in EVAL.
- Per-bit latency without slips: 32*(SETTLE_CYCLES+4)+2 cycles.
- Reset mid-operation returns to IDLE immediately. The datapath keeps whatever delay was last loaded.
- start_i in DONE or busy is ignored. start_i and host access in the same IDLE cycle: the host access passes through that cycle.

Decomposition:
- Shared package: register address constants (DPTRAINING=2, DPIDELAY=4), field positions (load bit31, bitslip bit30, select [22:16], delay [4:0]), NUM_CH=6, NUM_BIT=12, state enum.
- One natural sub-module, ritc_eye_tracker: run/best length and start tracking plus centre computation (inputs match, eval strobe, clear, tap).

Test Plan:
- Idle passthrough: host writes addr 4 data 0x8012_0007 -> identical bus write in the same cycle; host_dat_o follows bus_dat_i.
- Full pass: model returns pattern_i=0xA5 for taps 10-20 on every bit -> each bit gets a final addr-4 write with tap 15; done_o pulses; fail_count_o=0; no bitslip writes.
- Tie/boundary: matching taps 2-5 and 27-31 -> centre 29. Runs 0-3 and 8-11 -> centre 2 (first run wins).
- Bitslip: bit {3,4} matches only after 2 bitslips, taps 5-9 -> exactly 2 addr-2 writes with bit30 and select 0x34, then centre 7.
- Failure: bit {0,0} never matches, MIN_EYE=3 -> 4 slips, fail_o=1, fail_count_o=1, sequence continues to bit {0,1}.
- Reset/ignore: assert rst_i in SETTLE of bit 20 -> all outputs 0 within the reset cycle; start_i while busy_o=1 has no effect; host writes during busy produce no bus activity.
